// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The opcode/jump-index field bounds assume the 32-bit instruction encoding.
package fetch_pkg;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam int unsigned OPC_HI           = 31;
    localparam int unsigned OPC_LO           = 26;
    localparam int unsigned JIDX_HI          = 25;
    localparam int unsigned JIDX_LO          = 0;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory port plus the decode/execute handshake.
// The master view belongs to the fetch stage and the slave view to its environment.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) ();

    logic [ADDR_W-1:0]  Address;
    logic [INSTR_W-1:0] ReadData;
    logic [INSTR_W-1:0] Instr;
    logic [ADDR_W-1:0]  InstrPC;
    logic               InstrValid;
    logic               Stall;
    logic               Redirect;
    logic [ADDR_W-1:0]  RedirectPC;
    logic               PredTaken;

    modport master (
        output Address,
        output Instr,
        output InstrPC,
        output InstrValid,
        output PredTaken,
        input  ReadData,
        input  Stall,
        input  Redirect,
        input  RedirectPC
    );

    modport slave (
        input  Address,
        input  Instr,
        input  InstrPC,
        input  InstrValid,
        input  PredTaken,
        output ReadData,
        output Stall,
        output Redirect,
        output RedirectPC
    );

endinterface

// File: rtl/jump_predecode.sv
// Combinational J-type detector: flags an accepted jump and forms its target
// from the upper bits of the jump's own PC and the 26-bit instruction index.
module jump_predecode
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic                       valid_i,
    input  logic [INSTR_W-1:0]         instr_i,
    input  logic [ADDR_W-JIDX_HI-2:0]  f_pc_hi_i,
    output logic                       hit_o,
    output logic [ADDR_W-1:0]          target_o
);

    assign hit_o    = valid_i & (instr_i[OPC_HI:OPC_LO] == OP_J);
    assign target_o = {f_pc_hi_i, instr_i[JIDX_HI:JIDX_LO]};

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the 1-cycle-latency instruction memory and
// replays the in-flight fetch on stall. Optional jump predecode: FETCH_JUMP_PREDECODE_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    instruction_fetch_if.master  fetch_bus
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] f_pc_q, f_pc_d;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pred_target;
    logic              f_valid;
    logic              instr_valid;
    logic              replay;
    logic              pred_hit;

    // The in-flight fetch exists exactly when the FSM has left BOOT.
    assign f_valid     = (state_q == RUN);
    assign instr_valid = f_valid & ~fetch_bus.Redirect;

`ifdef FETCH_JUMP_PREDECODE_EN
    jump_predecode #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_jump_predecode (
        .valid_i   (instr_valid & ~fetch_bus.Stall),
        .instr_i   (fetch_bus.ReadData),
        .f_pc_hi_i (f_pc_q[ADDR_W-1:JIDX_HI+1]),
        .hit_o     (pred_hit),
        .target_o  (pred_target)
    );
`else
    assign pred_hit    = 1'b0;
    assign pred_target = '0;
`endif

    always_comb begin
        state_d = state_q;
        addr    = pc_q;
        replay  = 1'b0;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (fetch_bus.Redirect) begin
            addr = fetch_bus.RedirectPC;
        end else if (pred_hit) begin
            addr = pred_target;
        end else if (fetch_bus.Stall && f_valid) begin
            addr   = f_pc_q;
            replay = 1'b1;
        end

        f_pc_d = addr;
        // A replay refetches f_pc, so the sequential PC must not advance.
        pc_d   = replay ? pc_q : addr + ADDR_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= BOOT;
            pc_q    <= ResetPc;
            f_pc_q  <= ResetPc;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            f_pc_q  <= f_pc_d;
        end
    end

    assign fetch_bus.Address    = addr;
    assign fetch_bus.Instr      = fetch_bus.ReadData;
    assign fetch_bus.InstrPC    = f_pc_q;
    assign fetch_bus.InstrValid = instr_valid;
    assign fetch_bus.PredTaken  = pred_hit;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: per-cycle expectations are queued as
// stimulus is driven and compared mid-cycle against the DUT outputs.
module tb_instruction_fetch;

    logic clk;
    logic rst_n;

    instruction_fetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    instruction_fetch #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (0)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .fetch_bus (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        pred;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] mem [64];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] r_pc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read instruction memory, one cycle of latency.
    always @(posedge clk) bus.ReadData <= mem[bus.Address[5:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("InstrValid", 32'(bus.InstrValid), 32'(e.valid));
            check_eq("Address", bus.Address, e.addr);
            check_eq("PredTaken", 32'(bus.PredTaken), 32'(e.pred));
            if (e.valid) begin
                check_eq("InstrPC", bus.InstrPC, e.pc);
                check_eq("Instr", bus.Instr, mem[e.pc[5:0]]);
            end
        end
    end

    // Drive one cycle of inputs and queue what that cycle must show.
    task automatic drive(input logic stall, input logic redir, input logic [31:0] rpc,
                         input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                         input logic epred);
        exp_t x;
        bus.Stall      = stall;
        bus.Redirect   = redir;
        bus.RedirectPC = rpc;
        x.valid = ev;
        x.pc    = epc;
        x.addr  = eaddr;
        x.pred  = epred;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + 32'(i);
        mem[0]  = 32'h2001_0001;
        mem[2]  = 32'hAC34_0000;
        mem[10] = 32'h0800_0010;
        mem[16] = 32'h2042_0002;

        rst_n          = 1'b0;
        bus.Stall      = 1'b0;
        bus.Redirect   = 1'b0;
        bus.RedirectPC = 32'd0;
        #2;
        check_eq("rst_Address", bus.Address, 32'd0);
        check_eq("rst_InstrValid", 32'(bus.InstrValid), 32'd0);
        check_eq("rst_InstrPC", bus.InstrPC, 32'd0);
        check_eq("rst_PredTaken", 32'(bus.PredTaken), 32'd0);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Boot bubble, then sequential fetch.
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd1, 32'd2, 1'b0);
        // Three stalled cycles on PC 2, then it is accepted and PC 3 follows.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 32'd0, 1'b1, 32'd2, 32'd2, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd2, 32'd3, 1'b0);
        for (int k = 3; k <= 9; k++) drive(1'b0, 1'b0, 32'd0, 1'b1, 32'(k), 32'(k + 1), 1'b0);

`ifdef FETCH_JUMP_PREDECODE_EN
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd10, 32'd16, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd16, 32'd17, 1'b0);
        r_pc = 32'd17;
`else
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd10, 32'd11, 1'b0);
        r_pc = 32'd11;
`endif
        // Redirect squashes the current instruction; one bubble.
        drive(1'b0, 1'b1, 32'd16, 1'b0, r_pc, 32'd16, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd16, 32'd17, 1'b0);
        // Redirect overrides a simultaneous stall.
        drive(1'b1, 1'b1, 32'd16, 1'b0, 32'd17, 32'd16, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd16, 32'd17, 1'b0);
        // PC wraps from all-ones to zero.
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd17, 32'hFFFF_FFFF, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        drive(1'b0, 1'b1, 32'd5, 1'b0, 32'd0, 32'd5, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd5, 32'd6, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd6, 32'd7, 1'b0);

        // Reset mid-run while PC 7 is presented.
        check_eq("pre_rst_InstrPC", bus.InstrPC, 32'd7);
        check_eq("pre_rst_InstrValid", 32'(bus.InstrValid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_InstrValid", 32'(bus.InstrValid), 32'd0);
        check_eq("mid_rst_Address", bus.Address, 32'd0);
        check_eq("mid_rst_InstrPC", bus.InstrPC, 32'd0);
        check_eq("mid_rst_PredTaken", 32'(bus.PredTaken), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Stall during the boot bubble is ignored.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd1, 32'd2, 1'b0);

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly upstream of the synchronous-read instruction memory. It owns the program counter, drives the memory's `Address`, and pairs each returned `ReadData` word with the PC it was fetched from. It presents a valid/stall interface to the decode stage and accepts branch and jump redirects from execute. The memory has one cycle of read latency, so this block tracks the in-flight fetch and replays it during stalls.

## Interface
- `ADDR_W`, default 32: PC and `Address` width; word addressing, one instruction per address.
- `INSTR_W`, default 32: instruction width; must match the memory slot width.
- `RESET_PC`, default 0: first address fetched after reset.
- `Clk`, input, 1: single clock; all state changes on the rising edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `Address`, output, ADDR_W: fetch address to the instruction memory (combinational).
- `ReadData`, input, INSTR_W: memory output, valid one cycle after `Address`.
- `Instr`, output, INSTR_W: instruction to decode, a pass-through of `ReadData`.
- `InstrPC`, output, ADDR_W: PC of `Instr`.
- `InstrValid`, output, 1: `Instr`/`InstrPC` are meaningful this cycle.
- `Stall`, input, 1: decode cannot accept; hold the current output.
- `Redirect`, input, 1: execute resolved a taken branch/jump; squash and refetch.
- `RedirectPC`, input, ADDR_W: redirect target word address.
- `PredTaken`, output, 1: fetch already followed this instruction's jump (see Configuration).

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `f_pc`: address whose data is on `ReadData` this cycle.
  - `f_valid`: an in-flight fetch exists.
- Outputs:
  - `InstrValid = f_valid & ~Redirect`.
  - `InstrPC = f_pc`.
  - `Instr = ReadData`.
- `Address` priority, highest first:
  1. `Redirect` → `RedirectPC`.
  2. Predecoded jump target (macro only).
  3. `Stall & f_valid` → `f_pc` (replay).
  4. Otherwise → `pc`.
- Each edge: `f_pc <= Address`, `f_valid <= 1`, `pc <= Address + 1`.
  - Exception: on a replay, `pc` holds.
- `Stall` while `InstrValid` is 0 is ignored; a bubble cannot stall.
- `Redirect` and `Stall` together: `Redirect` wins and the stalled instruction is squashed.
- PC arithmetic is modulo 2^ADDR_W. `pc` wraps from all-ones to 0 silently.
- Out-of-range addresses are the memory's concern.
- Two-state FSM:
  - `BOOT`: entered on reset. `f_valid`=0. Moves to `RUN` on the first edge.
  - `RUN`: steady state. Only reset returns the FSM to `BOOT`.

## Timing
- Reset values, applied asynchronously:
  - `pc`=`RESET_PC`, `f_pc`=`RESET_PC`, `f_valid`=0.
  - Outputs: `Address`=`RESET_PC`, `InstrValid`=0, `InstrPC`=`RESET_PC`, `PredTaken`=0.
- Reset asserted mid-operation:
  - `InstrValid` drops in the same cycle; no edge is needed.
  - The in-flight fetch is discarded.
- Latency:
  - First `InstrValid` appears in the cycle after the first edge following reset release.
  - Steady state delivers one instruction per cycle.
- Stall: `Instr`/`InstrPC` hold stable for every cycle `Stall` is high. The next PC follows in the cycle after `Stall` falls.
- Redirect penalty: one bubble. The target is valid in the cycle after `Redirect`.

## Configuration
- Macro `FETCH_JUMP_PREDECODE_EN`.
- Defined:
  - When `InstrValid & ~Stall` and `Instr[31:26]`=`6'b000010`, `Address` becomes `{f_pc[ADDR_W-1:26], Instr[25:0]}`. Redirect has higher priority.
  - `PredTaken`=1 with that instruction.
  - No bubble: the target's data follows the jump directly.
  - Execute must not redirect on a `PredTaken` jump.
- Undefined:
  - `PredTaken` is tied to 0.
  - Jumps flow sequentially until execute redirects.

## Structure
- Shared package `fetch_pkg`:
  - `OP_J` = `6'b000010`.
  - Opcode field bounds (31:26) and jump-index bounds (25:0).
  - Default `RESET_PC`.
  - FSM state typedef (`BOOT`, `RUN`).
- Sub-module `jump_predecode`: combinational opcode match plus target formation. Instantiated only under the macro.

## Test plan
- **Reset/run**:
  - Stimulus: release `Reset_n`.
  - Response: `Address` 0,1,2 on successive cycles; first valid cycle shows `InstrPC`=0, `Instr`=`0x20010001`; no gaps after that.
- **Stall**:
  - Stimulus: `Stall` high for 3 cycles while `InstrPC`=2.
  - Response: `Instr`=`0xAC340000` and `InstrPC`=2 hold for those 3 cycles, then `InstrPC`=3.
- **Redirect**:
  - Stimulus: `Redirect`=1, `RedirectPC`=16 while `InstrPC`=11.
  - Response: `InstrValid`=0 that cycle; next cycle `InstrPC`=16, `Instr`=`0x20420002`.
- **Redirect and Stall together**:
  - Stimulus: both high, `RedirectPC`=16.
  - Response: the stall is overridden; `InstrPC`=16 next cycle.
- **Jump with macro**:
  - Stimulus: fetch runs past `InstrPC`=10, `Instr`=`0x08000010`.
  - Response: `PredTaken`=1; `InstrPC` sequence 9,10,16 with no bubble.
  - Without the macro: sequence 10,11 until `Redirect`, and `PredTaken` stays 0.
- **Reset mid-run**:
  - Stimulus: `Reset_n` low while `InstrPC`=7.
  - Response: `InstrValid`=0 and `Address`=0 before the next edge; after release, fetch restarts from 0.
